inst_fetch_ctrl: RTL and testbench

Fetch stage directly downstream of the program counter. It takes the PC value and fetch enable, issues one request at a time to the L1 I-cache, and pairs each returned instruction with its PC. Pairs are buffered in a small queue that feeds decode. It back-pressures the PC through stall_o and discards in-flight fetches on flush.

---
 rtl/if_pkg.sv | 21 ++
 rtl/inst_fetch_queue.sv | 66 ++++++
 rtl/inst_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding, queue entry layout
// and the reset state.
package if_pkg;

    localparam int IF_AW = 32;
    localparam int IF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IF_AW-1:0] pc;
        logic [IF_DW-1:0] inst;
    } fetch_entry_t;

    localparam fetch_state_e FETCH_RST_STATE = ST_IDLE;

endpackage

// File: rtl/inst_fetch_queue.sv
// Small FIFO of {pc, inst} pairs between the I-cache response and decode.
// Clear wins over push and pop; the head is read combinationally from the array.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o,
    output logic [W-1:0]  head_o
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i & ~clear_i & (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i & ~clear_i & (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: one outstanding I-cache request at a time, pairs each
// response with its PC and queues it for decode; flush squashes in-flight work.
module inst_fetch_ctrl
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = IF_AW,
    parameter int DW    = IF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          ce_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic          icache_req,
    output logic [AW-1:0] icache_addr,
    input  logic          icache_gnt,
    input  logic          icache_rvalid,
    input  logic [DW-1:0] icache_rdata,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst,
    input  logic          id_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0] q_count;
    logic [CW:0]   occupancy;
    logic          space;
    logic          can_issue;
    logic          fire;
    logic          push;
    logic          pop;
    logic [AW+DW-1:0] q_head;

    // An outstanding request already owns a slot, so it counts against space.
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, (state_q == ST_WAIT)};
    assign space     = occupancy < (CW+1)'(DEPTH);
    assign can_issue = ce_i & ~flush_i & space &
                       ((state_q == ST_IDLE) | ((state_q == ST_WAIT) & icache_rvalid));

    // Masking with rst keeps the request low and the PC held while in reset.
    assign icache_req  = can_issue & rst;
    assign fire        = icache_req & icache_gnt;
    assign stall_o     = ~fire;
    assign icache_addr = pc_i;
    assign pop         = id_valid & id_ready;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = icache_rvalid ? ST_IDLE : ST_DROP;
                end else if (icache_rvalid) begin
                    push    = 1'b1;
                    state_d = fire ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DROP: begin
                // The response owed to the squashed path is swallowed here.
                if (icache_rvalid) state_d = ST_IDLE;
            end
            default: state_d = FETCH_RST_STATE;
        endcase
        if (fire) req_pc_d = pc_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH_RST_STATE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (push),
        .push_data_i ({req_pc_q, icache_rdata}),
        .pop_i       (pop),
        .clear_i     (flush_i),
        .count_o     (q_count),
        .valid_o     (id_valid),
        .head_o      (q_head)
    );

    assign id_pc   = q_head[AW+DW-1:DW];
    assign id_inst = q_head[DW-1:0];

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomised bench for inst_fetch_ctrl: the bench acts as PC stage, I-cache and
// decode, and predicts every output from a queue-based model of the fetch rules.
module tb_inst_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i, flush_i, gnt, rvalid, id_ready;
    logic [31:0] rdata;
    logic        stall_o, icache_req, id_valid;
    logic [31:0] icache_addr, id_pc, id_inst;

    inst_fetch_ctrl #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_gnt    (gnt),
        .icache_rvalid (rvalid),
        .icache_rdata  (rdata),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_ready      (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Model: expected decode queue and the fate of the single outstanding fetch.
    ent_t        mq[$];
    int          mout;          // 0 none, 1 live, 2 squashed
    logic [31:0] mlive_pc;
    logic [31:0] pc_nxt;

    // Cache responder: one pending response with a countdown.
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_data;

    int k_ce, k_gnt, k_flush, k_ready, lat_lo, lat_hi;
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit can, fire, space, pop;
        pc_i     = pc_nxt;
        ce_i     = ($urandom_range(99) < k_ce);
        gnt      = ($urandom_range(99) < k_gnt);
        flush_i  = ($urandom_range(99) < k_flush);
        id_ready = ($urandom_range(99) < k_ready);
        rvalid   = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                rvalid = 1'b1;
                pend   = 1'b0;
            end
        end
        rdata = rvalid ? pend_data : $urandom();
        #1;
        space = (mq.size() + ((mout == 1) ? 1 : 0)) < DEPTH;
        can   = ce_i && !flush_i && space && (mout == 0 || (mout == 1 && rvalid));
        fire  = can && gnt;
        check_val("icache_req", 64'(icache_req), 64'(can));
        check_val("stall_o", 64'(stall_o), 64'(!fire));
        if (can) check_val("icache_addr", 64'(icache_addr), 64'(pc_i));
        check_val("id_valid", 64'(id_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_val("id_pc", 64'(id_pc), 64'(mq[0].pc));
            check_val("id_inst", 64'(id_inst), 64'(mq[0].inst));
        end
        pop = (mq.size() > 0) && id_ready;
        if (flush_i) begin
            mq.delete();
            if (mout != 0) mout = rvalid ? 0 : 2;
        end else begin
            if (pop) begin
                $display("decode pc=%08h inst=%08h", mq[0].pc, mq[0].inst);
                void'(mq.pop_front());
            end
            if (mout == 1 && rvalid) begin
                mq.push_back('{pc: mlive_pc, inst: rdata});
                mout = 0;
            end else if (mout == 2 && rvalid) begin
                mout = 0;
            end
            if (fire) begin
                mout     = 1;
                mlive_pc = pc_i;
            end
        end
        if (fire) begin
            pend      = 1'b1;
            pend_cnt  = $urandom_range(lat_hi, lat_lo);
            pend_data = $urandom();
        end
        if (flush_i)   pc_nxt = 32'h1000_0100 + ($urandom_range(63) << 2);
        else if (fire) pc_nxt = pc_i + 32'd4;
        @(negedge clk);
    endtask

    task automatic knobs(input int ce, input int g, input int fl, input int rd, input int lo, input int hi);
        k_ce = ce; k_gnt = g; k_flush = fl; k_ready = rd; lat_lo = lo; lat_hi = hi;
    endtask

    initial begin
        rst = 1'b0; ce_i = 1'b1; gnt = 1'b1; flush_i = 1'b0; rvalid = 1'b0;
        rdata = '0; id_ready = 1'b1;
        pc_i = 32'h1000_0000; pc_nxt = 32'h1000_0000;
        mout = 0; pend = 1'b0; pend_cnt = 0; mlive_pc = '0; pend_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_id_valid", 64'(id_valid), 64'd0);
        check_val("rst_icache_req", 64'(icache_req), 64'd0);
        check_val("rst_stall_o", 64'(stall_o), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        knobs(100, 100, 0, 100, 1, 1);  repeat (30) step();   // hit stream
        knobs(100, 100, 0, 100, 5, 5);  repeat (30) step();   // misses
        knobs(100, 100, 0, 0, 1, 1);    repeat (12) step();   // decode stall
        knobs(100, 100, 0, 100, 1, 1);  repeat (10) step();
        knobs(100, 90, 15, 80, 3, 5);   repeat (80) step();   // flushes around misses

        // Reset in the middle of a miss, then a stale response after release.
        knobs(100, 100, 0, 100, 5, 5);
        for (int i = 0; i < 20 && mout != 0; i++) step();
        for (int i = 0; i < 20 && mout != 1; i++) step();
        check_val("wait_for_miss", 64'(mout), 64'd1);
        step();
        rst = 1'b0; ce_i = 1'b1; gnt = 1'b1;
        #1;
        check_val("midmiss_id_valid", 64'(id_valid), 64'd0);
        check_val("midmiss_icache_req", 64'(icache_req), 64'd0);
        check_val("midmiss_stall_o", 64'(stall_o), 64'd1);
        mq.delete(); mout = 0; pc_nxt = 32'h1000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        knobs(0, 100, 0, 100, 1, 1);
        for (int i = 0; i < 20 && pend; i++) step();
        check_val("stale_rvalid_seen", 64'(pend), 64'd0);
        step();
        knobs(100, 100, 0, 100, 1, 1);  repeat (10) step();

        knobs(80, 70, 5, 60, 1, 4);     repeat (1500) step(); // random mix

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
